wt_mem_req_arbiter: RTL and testbench

// - N-channel successor to the fixed two-client (I$/D$) memory plumbing of the write-through cache subsystem.
// - Merges NumChan cache request streams into one memory request port (AXI or L1.5 adapter side).
// - Round-robin arbitration; channel index tagged into the outgoing transaction ID.
// - Returns routed back to the owning channel by ID; per-channel outstanding-transaction limits enforced.

---
 rtl/wt_mem_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wt_mem_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin merge of NumChan cache request streams onto one memory port, with ID-based return routing.
// Optional per-channel grant counters are enabled by defining WT_ARB_PERF_CNT_EN.
module wt_mem_req_arbiter #(
  parameter int unsigned NumChan = 2,
  parameter int unsigned ReqW    = 128,
  parameter int unsigned RtrnW   = 256,
  parameter int unsigned TidW    = 2,
  parameter int unsigned MaxTx   = 4,
  localparam int unsigned ChanW  = (NumChan > 1) ? $clog2(NumChan) : 1,
  localparam int unsigned IdW    = ChanW + TidW
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic [NumChan-1:0]      req_valid_i,
  output logic [NumChan-1:0]      req_ready_o,
  input  logic [NumChan*ReqW-1:0] req_data_i,
  input  logic [NumChan*TidW-1:0] req_tid_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ReqW-1:0]         mem_req_data_o,
  output logic [IdW-1:0]          mem_req_tid_o,
  input  logic                    mem_rtrn_vld_i,
  input  logic [RtrnW-1:0]        mem_rtrn_data_i,
  input  logic [IdW-1:0]          mem_rtrn_tid_i,
  output logic [NumChan-1:0]      rtrn_vld_o,
  output logic [RtrnW-1:0]        rtrn_data_o,
  output logic [TidW-1:0]         rtrn_tid_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [NumChan*32-1:0]   perf_gnt_cnt_o
);

  localparam int unsigned CntW = $clog2(MaxTx + 1);

  logic [CntW-1:0]    r_cnt [NumChan];
  logic [ChanW-1:0]   r_rr_ptr;
  logic               r_valid;
  logic [ReqW-1:0]    r_data;
  logic [IdW-1:0]     r_tid;
  logic               r_err;

  logic [NumChan-1:0] w_elig;
  logic [NumChan-1:0] w_cnt_nz;
  logic [NumChan-1:0] w_grant;
  logic [NumChan-1:0] w_accept;
  logic [NumChan-1:0] w_rtrn_hit;
  logic [NumChan-1:0] w_rtrn_vld;
  logic               w_any_grant;
  logic               w_slot_free;
  logic               w_illegal;
  logic [ChanW-1:0]   w_gnt_idx;
  logic [ChanW-1:0]   w_ptr_nxt;
  logic [ChanW-1:0]   w_rtrn_chan;

  // A channel at its outstanding limit is simply not eligible, so the pointer never stalls on it.
  always_comb begin
    w_elig   = '0;
    w_cnt_nz = '0;
    for (int i = 0; i < int'(NumChan); i++) begin
      w_elig[i]   = req_valid_i[i] && (r_cnt[i] < CntW'(MaxTx));
      w_cnt_nz[i] = (r_cnt[i] != '0);
    end
  end

  // First eligible channel at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    logic [ChanW-1:0] idx_c;
    idx         = 0;
    idx_c       = '0;
    w_grant     = '0;
    w_gnt_idx   = '0;
    w_any_grant = 1'b0;
    for (int k = 0; k < int'(NumChan); k++) begin
      idx = 32'(r_rr_ptr) + 32'(k);
      if (idx >= NumChan) idx = idx - NumChan;
      idx_c = ChanW'(idx);
      if (!w_any_grant && w_elig[idx_c]) begin
        w_any_grant      = 1'b1;
        w_grant[idx_c]   = 1'b1;
        w_gnt_idx        = idx_c;
      end
    end
  end

  assign w_slot_free = !r_valid || mem_req_ready_i;
  assign w_accept    = w_grant & {NumChan{w_slot_free}};
  assign req_ready_o = w_accept;
  assign w_ptr_nxt   = (32'(w_gnt_idx) == NumChan - 1) ? '0 : w_gnt_idx + ChanW'(1);

  // Returns go only to a channel that exists and has something outstanding.
  assign w_rtrn_chan = mem_rtrn_tid_i[TidW +: ChanW];
  always_comb begin
    w_rtrn_hit = '0;
    for (int c = 0; c < int'(NumChan); c++) begin
      w_rtrn_hit[c] = (w_rtrn_chan == ChanW'(c));
    end
  end
  assign w_rtrn_vld  = {NumChan{mem_rtrn_vld_i}} & w_rtrn_hit & w_cnt_nz;
  assign w_illegal   = mem_rtrn_vld_i && !(|w_rtrn_vld);
  assign rtrn_vld_o  = w_rtrn_vld;
  assign rtrn_data_o = mem_rtrn_data_i;
  assign rtrn_tid_o  = mem_rtrn_tid_i[TidW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumChan); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NumChan); i++) begin
        case ({w_accept[i], w_rtrn_vld[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CntW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CntW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (clr_i) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant && w_slot_free) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Output stage: reload on accept, drain on ready, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tid   <= '0;
    end else if (w_any_grant && w_slot_free) begin
      r_valid <= 1'b1;
      r_data  <= req_data_i[w_gnt_idx*ReqW +: ReqW];
      r_tid   <= {w_gnt_idx, req_tid_i[w_gnt_idx*TidW +: TidW]};
    end else if (mem_req_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (clr_i) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign mem_req_valid_o = r_valid;
  assign mem_req_data_o  = r_data;
  assign mem_req_tid_o   = r_tid;
  assign err_o           = r_err;
  assign busy_o          = r_valid || (|w_cnt_nz);

`ifdef WT_ARB_PERF_CNT_EN
  logic [31:0] r_perf [NumChan];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumChan); i++) r_perf[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NumChan); i++) begin
        if (clr_i) begin
          r_perf[i] <= '0;
        end else if (w_accept[i] && req_valid_i[i]) begin
          r_perf[i] <= r_perf[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int i = 0; i < int'(NumChan); i++) perf_gnt_cnt_o[i*32 +: 32] = r_perf[i];
  end
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Bench for wt_mem_req_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against a counter/queue-level reference model.
module tb_wt_mem_req_arbiter;

  localparam int unsigned NumChan = 2;
  localparam int unsigned ReqW    = 128;
  localparam int unsigned RtrnW   = 256;
  localparam int unsigned TidW    = 2;
  localparam int unsigned MaxTx   = 4;
  localparam int unsigned ChanW   = 1;
  localparam int unsigned IdW     = ChanW + TidW;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    clr_i;
  logic [NumChan-1:0]      req_valid_i;
  logic [NumChan-1:0]      req_ready_o;
  logic [NumChan*ReqW-1:0] req_data_i;
  logic [NumChan*TidW-1:0] req_tid_i;
  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i;
  logic [ReqW-1:0]         mem_req_data_o;
  logic [IdW-1:0]          mem_req_tid_o;
  logic                    mem_rtrn_vld_i;
  logic [RtrnW-1:0]        mem_rtrn_data_i;
  logic [IdW-1:0]          mem_rtrn_tid_i;
  logic [NumChan-1:0]      rtrn_vld_o;
  logic [RtrnW-1:0]        rtrn_data_o;
  logic [TidW-1:0]         rtrn_tid_o;
  logic                    busy_o;
  logic                    err_o;
  logic [NumChan*32-1:0]   perf_gnt_cnt_o;

  wt_mem_req_arbiter #(
    .NumChan(NumChan), .ReqW(ReqW), .RtrnW(RtrnW), .TidW(TidW), .MaxTx(MaxTx)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_tid_i(req_tid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_data_o(mem_req_data_o), .mem_req_tid_o(mem_req_tid_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .rtrn_vld_o(rtrn_vld_o),
    .rtrn_data_o(rtrn_data_o), .rtrn_tid_o(rtrn_tid_o),
    .busy_o(busy_o), .err_o(err_o), .perf_gnt_cnt_o(perf_gnt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding counts, pointer, output slot contents, sticky error, grant counts.
  int             m_cnt [NumChan];
  int             m_ptr;
  bit             m_ov;
  logic [ReqW-1:0] m_od;
  logic [IdW-1:0] m_ot;
  bit             m_err;
  logic [31:0]    m_perf [NumChan];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(NumChan); i++) begin
      m_cnt[i]  = 0;
      m_perf[i] = '0;
    end
    m_ptr = 0;
    m_ov  = 0;
    m_od  = '0;
    m_ot  = '0;
    m_err = 0;
  endfunction

  function automatic int grant_idx();
    for (int k = 0; k < int'(NumChan); k++) begin
      int i;
      i = (m_ptr + k) % int'(NumChan);
      if (req_valid_i[i] && m_cnt[i] < int'(MaxTx)) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic [NumChan-1:0] v, input logic rdy, input logic rv,
                       input logic [IdW-1:0] rtid, input logic c);
    req_valid_i     = v;
    mem_req_ready_i = rdy;
    mem_rtrn_vld_i  = rv;
    mem_rtrn_tid_i  = rtid;
    clr_i           = c;
    for (int i = 0; i < int'(NumChan); i++) begin
      req_data_i[i*ReqW +: ReqW] = {$urandom, $urandom, $urandom, $urandom};
      req_tid_i[i*TidW +: TidW]  = TidW'($urandom);
    end
    mem_rtrn_data_i = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    #1;
  endtask

  // Compare every output with the model, advance the model, and move to just after the next edge.
  task automatic tick();
    int g, ch;
    bit free, acc, legal, eb;
    logic [NumChan-1:0] er, ev;
    logic [31:0] ep;
    g     = grant_idx();
    free  = !m_ov || mem_req_ready_i;
    acc   = (g >= 0) && free;
    er    = '0;
    if (acc) er[g] = 1'b1;
    ch    = int'(mem_rtrn_tid_i >> TidW);
    legal = mem_rtrn_vld_i && (ch < int'(NumChan)) && (m_cnt[ch] > 0);
    ev    = '0;
    if (legal) ev[ch] = 1'b1;
    eb    = m_ov;
    for (int i = 0; i < int'(NumChan); i++) if (m_cnt[i] > 0) eb = 1;

    chk("req_ready", 256'(req_ready_o), 256'(er));
    chk("mem_valid", 256'(mem_req_valid_o), 256'(m_ov));
    if (m_ov) begin
      chk("mem_data", 256'(mem_req_data_o), 256'(m_od));
      chk("mem_tid", 256'(mem_req_tid_o), 256'(m_ot));
    end
    chk("rtrn_vld", 256'(rtrn_vld_o), 256'(ev));
    chk("rtrn_tid", 256'(rtrn_tid_o), 256'(mem_rtrn_tid_i[TidW-1:0]));
    chk("rtrn_data", 256'(rtrn_data_o), 256'(mem_rtrn_data_i));
    chk("busy", 256'(busy_o), 256'(eb));
    chk("err", 256'(err_o), 256'(m_err));
    for (int i = 0; i < int'(NumChan); i++) begin
`ifdef WT_ARB_PERF_CNT_EN
      ep = m_perf[i];
`else
      ep = '0;
`endif
      chk("perf", 256'(perf_gnt_cnt_o[i*32 +: 32]), 256'(ep));
    end

    if (acc) begin
      m_ov = 1;
      m_od = req_data_i[g*ReqW +: ReqW];
      m_ot = {ChanW'(g), req_tid_i[g*TidW +: TidW]};
      m_cnt[g]++;
      m_perf[g] = m_perf[g] + 32'd1;
    end else if (mem_req_ready_i) begin
      m_ov = 0;
    end
    if (legal) m_cnt[ch]--;
    else if (mem_rtrn_vld_i) m_err = 1;
    if (clr_i) begin
      m_ptr = 0;
      m_err = 0;
      for (int i = 0; i < int'(NumChan); i++) m_perf[i] = '0;
    end else if (acc) begin
      m_ptr = (g + 1) % int'(NumChan);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    model_reset();
    chk("rst_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [ReqW-1:0] d1;
    logic [IdW-1:0]  t1;
    logic [31:0]     exp_perf;
    rst_ni          = 1'b1;
    clr_i           = 1'b0;
    req_valid_i     = '0;
    req_data_i      = '0;
    req_tid_i       = '0;
    mem_req_ready_i = 1'b0;
    mem_rtrn_vld_i  = 1'b0;
    mem_rtrn_data_i = '0;
    mem_rtrn_tid_i  = '0;
    #2;

    // Both channels requesting with a free memory side: grants alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
      if (k < 4) chk("alt_ready", 256'(req_ready_o), 256'((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k >= 1) chk("alt_tid_chan", 256'(mem_req_tid_o[IdW-1]), 256'((k - 1) % 2));
      tick();
    end

    // Channel 0 fills its four slots, is skipped while channel 1 still wins, then recovers on return.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
      chk("fill_ready", 256'(req_ready_o), 256'(2'b01));
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("full_skip", 256'(req_ready_o), 256'(2'b10));
    tick();
    drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
    chk("full_hold", 256'(req_ready_o), 256'(2'b00));
    tick();
    drive(2'b01, 1'b1, 1'b1, 3'b010, 1'b0);
    chk("full_rtrn_vld", 256'(rtrn_vld_o), 256'(2'b01));
    chk("full_rtrn_tid", 256'(rtrn_tid_o), 256'(2'd2));
    chk("full_rtrn_ready", 256'(req_ready_o), 256'(2'b00));
    tick();
    drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
    chk("reelig", 256'(req_ready_o), 256'(2'b01));
    tick();

    // Memory stalls for three cycles: output stage holds and nothing is accepted.
    do_reset();
    drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
    d1 = req_data_i[ReqW +: ReqW];
    t1 = {1'b1, req_tid_i[TidW +: TidW]};
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
      chk("stall_ready", 256'(req_ready_o), 256'(2'b00));
      chk("stall_data", 256'(mem_req_data_o), 256'(d1));
      chk("stall_tid", 256'(mem_req_tid_o), 256'(t1));
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("stall_resume", 256'(req_ready_o), 256'(2'b01));
    tick();

    // Accept and return on channel 1 together leave its count at 2: only two more fit.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
      tick();
    end
    drive(2'b10, 1'b1, 1'b1, 3'b100, 1'b0);
    chk("same_ready", 256'(req_ready_o), 256'(2'b10));
    chk("same_rtrn", 256'(rtrn_vld_o), 256'(2'b10));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
      chk("same_cnt", 256'(req_ready_o), 256'((k < 2) ? 2'b10 : 2'b00));
      tick();
    end

    // Return to an idle channel is dropped and flags a sticky error until clr_i.
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 3'b100, 1'b0);
    chk("illegal_vld", 256'(rtrn_vld_o), 256'(2'b00));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
    chk("err_set", 256'(err_o), 256'(1));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
    chk("err_sticky", 256'(err_o), 256'(1));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
    chk("err_clr", 256'(err_o), 256'(0));
    tick();

    // Ten accepts on channel 0, kept below the limit by returning one per cycle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 1'b1, (k > 0), 3'b000, 1'b0);
      tick();
    end
    drive(2'b00, 1'b1, 1'b0, '0, 1'b0);
`ifdef WT_ARB_PERF_CNT_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_ten", 256'(perf_gnt_cnt_o[31:0]), 256'(exp_perf));
    tick();

    // Randomized traffic with occasional illegal returns, clears and one mid-run async reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [NumChan-1:0] v;
      logic rdy, rv, c;
      logic [IdW-1:0] rtid;
      int ch;
      if (n == 1500) do_reset();
      v    = NumChan'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      c    = ($urandom_range(0, 99) == 0);
      rv   = 1'b0;
      ch   = int'($urandom_range(0, NumChan - 1));
      rtid = {ChanW'(ch), TidW'($urandom)};
      if ($urandom_range(0, 2) == 0) begin
        if (m_cnt[ch] > 0) rv = 1'b1;
        else if ($urandom_range(0, 19) == 0) rv = 1'b1;
      end
      drive(v, rdy, rv, rtid, c);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
